seri_besleyici: RTL and testbench
=================================

# seri_besleyici

Parallel-to-serial bit feeder that sits directly upstream of the serial sequence-detector FSM and drives its one-bit `giris` input. It accepts a data word on a load strobe and presents it one bit at a time on `cikis_bit`. Each bit is held for a programmable number of clock cycles. Between words it idles at logic 1, which keeps the downstream FSM parked in its reset state.

## Interface
- `VERI_GENISLIGI`, 8: word width in bits; must be ≥ 2.
- `BOLME`, 4: clock cycles each bit is held; must be ≥ 1 (0 is illegal).
- `saat` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: reset is asynchronous and active-high.
- `yukle` input 1: load request; sampled only while idle.
- `veri` input VERI_GENISLIGI: word to serialise; captured on the accepting edge.
- `cikis_bit` output 1: serial bit; connects to the downstream `giris`.
- `bit_adim` output 1: one-cycle strobe in the first cycle of each new bit.
- `mesgul` output 1: high while a word (and parity bit, if enabled) is being shifted.
- `bitti` output 1: one-cycle strobe in the first idle cycle after the last bit.

## Operation
- States: BOSTA (idle), VERI (data bits), PARITE (parity bit, only under the macro).
- All outputs are registered.
- Reset values: state BOSTA, `cikis_bit` = 1, `bit_adim` = 0, `mesgul` = 0, `bitti` = 0, all counters = 0.
- BOSTA:
  - `cikis_bit` = 1, `mesgul` = 0.
  - If `yukle` = 1 at an edge: capture `veri` into the shift register, go to VERI, clear the hold counter, set the bit counter to VERI_GENISLIGI−1.
- VERI:
  - `cikis_bit` = current MSB of the shift register; words are sent MSB first.
  - The hold counter counts 0..BOLME−1.
  - On wrap, if bits remain: shift left by one, decrement the bit counter, pulse `bit_adim`.
  - On wrap with the bit counter at 0: go to PARITE if enabled, else BOSTA with `bitti` pulsed.
- PARITE: `cikis_bit` = XOR of the captured word (even parity), held BOLME cycles, then BOSTA with `bitti` pulsed.
- Widths:
  - Hold counter is clog2(BOLME) bits, minimum 1.
  - Bit counter is clog2(VERI_GENISLIGI) bits.
  - No arithmetic overflow is permitted; counters compare against terminal values rather than relying on wrap.
- Boundary conditions:
  - `yukle` while `mesgul` = 1: ignored; the shift register is unchanged and no pending flag is kept.
  - `yukle` in the same cycle `bitti` is high: state is already BOSTA, so the request is accepted.
  - `yukle` held high continuously: words repeat, separated by exactly one idle cycle at `cikis_bit` = 1.
  - `reset` asserted mid-word: all outputs and state return to reset values immediately, with no `bitti` pulse. After release, the FSM waits for a fresh `yukle`.
  - BOLME = 1: one bit per clock, and `bit_adim` is high every busy cycle.

## Timing
- Load latency: with `yukle` accepted at edge k, the first bit appears and `mesgul` = 1 and `bit_adim` = 1 after edge k (cycle k+1).
- Bit i (0-based) occupies cycles k+1+i·BOLME through k+(i+1)·BOLME.
- Busy duration: VERI_GENISLIGI·BOLME cycles, plus BOLME with parity.
- `bitti` is high in cycle k+1+busy; `mesgul` is 0 in that same cycle.
- `cikis_bit` changes only on `bit_adim` cycles or on the BOSTA transition, so the downstream FSM sees a glitch-free level for BOLME edges.

## Configuration
- Macro `SERI_PARITE_EN`.
  - Defined: the PARITE state exists and one even-parity bit is appended after the data bits.
  - Undefined: there is no PARITE state, and the FSM goes VERI→BOSTA directly after the last data bit.

## Test plan
- Reset and idle: assert `reset` asynchronously mid-cycle, then release → `cikis_bit` = 1 and `mesgul`, `bit_adim`, `bitti` = 0 at once, and they stay there with `yukle` = 0.
- Basic word, BOLME = 4, no parity: `veri` = 8'b1011_0010, `yukle` pulsed at edge 0 →
  - `cikis_bit` = 1,0,1,1,0,0,1,0, each held 4 cycles over cycles 1–32;
  - `bit_adim` high at cycles 1,5,…,29;
  - `bitti` high at cycle 33.
- Parity build, same stimulus → 8 data bits, then parity bit 0 in cycles 33–36, and `bitti` at cycle 37. With `veri` = 8'b1011_0011, the parity bit is 1.
- Ignored load: a second `yukle` with `veri` = 8'hFF at cycle 10 of a transfer → the output sequence is unchanged and no second word follows `bitti`.
- Reset mid-word: assert `reset` at cycle 12 of a transfer → `cikis_bit` = 1 and `mesgul` = 0 immediately, with no `bitti`. A new `yukle` after release restarts from the MSB.
- Back-to-back, BOLME = 1: hold `yukle` high with `veri` = 8'hA5 → the bits 10100101 repeat with one idle cycle at 1 between words, and `bitti` and re-acceptance coincide.

Source files
------------

// File: rtl/seri_besleyici.sv
// seri_besleyici: parallel-to-serial bit feeder for the sequence-detector FSM.
// Loads a word on `yukle` while idle and shifts it out MSB first, each bit
// held BOLME clocks. Idles at logic 1 between words.
// Optional feature macro: SERI_PARITE_EN appends one even-parity bit.
module seri_besleyici #(
  parameter int VERI_GENISLIGI = 8,
  parameter int BOLME          = 4
) (
  input  logic                      saat,
  input  logic                      reset,
  input  logic                      yukle,
  input  logic [VERI_GENISLIGI-1:0] veri,
  output logic                      cikis_bit,
  output logic                      bit_adim,
  output logic                      mesgul,
  output logic                      bitti
);

  localparam int TW = (BOLME > 1) ? $clog2(BOLME) : 1;
  localparam int BW = $clog2(VERI_GENISLIGI);
  localparam logic [TW-1:0] TUTMA_SON = TW'(BOLME - 1);
  localparam logic [BW-1:0] BIT_ILK   = BW'(VERI_GENISLIGI - 1);

`ifdef SERI_PARITE_EN
  typedef enum logic [1:0] {BOSTA, VERI, PARITE} durum_t;
`else
  typedef enum logic {BOSTA, VERI} durum_t;
`endif

  durum_t                    durum, durum_d;
  logic [VERI_GENISLIGI-1:0] kaydirma;
  logic [TW-1:0]             tutma;
  logic [BW-1:0]             bit_say;
  logic                      tutma_son, bit_son;
  logic                      cikis_d, adim_d, mesgul_d, bitti_d;
`ifdef SERI_PARITE_EN
  logic                      parite;
`endif

  // Terminal-value compares; counters never rely on wrap-around.
  assign tutma_son = (tutma == TUTMA_SON);
  assign bit_son   = (bit_say == '0);

  // State and registered outputs; reset parks the line at 1 with no strobes.
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      durum     <= BOSTA;
      cikis_bit <= 1'b1;
      bit_adim  <= 1'b0;
      mesgul    <= 1'b0;
      bitti     <= 1'b0;
    end else begin
      durum     <= durum_d;
      cikis_bit <= cikis_d;
      bit_adim  <= adim_d;
      mesgul    <= mesgul_d;
      bitti     <= bitti_d;
    end
  end

  // Shift register, hold counter and bit counter.
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      kaydirma <= '0;
      tutma    <= '0;
      bit_say  <= '0;
`ifdef SERI_PARITE_EN
      parite   <= 1'b0;
`endif
    end else begin
      case (durum)
        BOSTA: begin
          if (yukle) begin
            kaydirma <= veri;
            tutma    <= '0;
            bit_say  <= BIT_ILK;
`ifdef SERI_PARITE_EN
            parite   <= ^veri;
`endif
          end
        end
        VERI: begin
          if (tutma_son) begin
            tutma <= '0;
            if (!bit_son) begin
              kaydirma <= kaydirma << 1;
              bit_say  <= bit_say - 1'b1;
            end
          end else begin
            tutma <= tutma + 1'b1;
          end
        end
`ifdef SERI_PARITE_EN
        PARITE: begin
          if (tutma_son) tutma <= '0;
          else           tutma <= tutma + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Next-state decision.
  always_comb begin
    durum_d = durum;
    case (durum)
      BOSTA: if (yukle) durum_d = VERI;
      VERI: begin
        if (tutma_son && bit_son) begin
`ifdef SERI_PARITE_EN
          durum_d = PARITE;
`else
          durum_d = BOSTA;
`endif
        end
      end
`ifdef SERI_PARITE_EN
      PARITE: if (tutma_son) durum_d = BOSTA;
`endif
      default: durum_d = BOSTA;
    endcase
  end

  // Next values of the registered outputs; the line only changes on a new bit
  // or on the return to idle, so the downstream FSM sees stable levels.
  always_comb begin
    cikis_d  = 1'b1;
    adim_d   = 1'b0;
    mesgul_d = 1'b0;
    bitti_d  = 1'b0;
    case (durum)
      BOSTA: begin
        if (yukle) begin
          cikis_d  = veri[VERI_GENISLIGI-1];
          adim_d   = 1'b1;
          mesgul_d = 1'b1;
        end
      end
      VERI: begin
        cikis_d  = cikis_bit;
        mesgul_d = 1'b1;
        if (tutma_son) begin
          if (!bit_son) begin
            cikis_d = kaydirma[VERI_GENISLIGI-2];
            adim_d  = 1'b1;
          end else begin
`ifdef SERI_PARITE_EN
            cikis_d = parite;
            adim_d  = 1'b1;
`else
            cikis_d  = 1'b1;
            mesgul_d = 1'b0;
            bitti_d  = 1'b1;
`endif
          end
        end
      end
`ifdef SERI_PARITE_EN
      PARITE: begin
        cikis_d  = cikis_bit;
        mesgul_d = 1'b1;
        if (tutma_son) begin
          cikis_d  = 1'b1;
          mesgul_d = 1'b0;
          bitti_d  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seri_besleyici.sv
// Bench for seri_besleyici: two instances (BOLME=4 and BOLME=1) checked every
// cycle against a timeline model derived from the load/bit/done timing rules.
module tb_seri_besleyici;

`ifdef SERI_PARITE_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W      = 8;
  localparam int BA     = 4;
  localparam int BB     = 1;
  localparam int BUSY_A = (W + PAR) * BA;
  localparam int BUSY_B = (W + PAR) * BB;

  logic saat = 1'b0, reset = 1'b1;
  logic ya = 1'b0, yb = 1'b0;
  logic [W-1:0] va = '0, vb = '0;
  logic ca, aa, ma, da, cb, ab, mb, db;

  int toplam = 0, hata = 0;
  int ta = 0, tb = 0;                 // cycles since accept edge, 0 = idle
  logic [W-1:0] wa = '0, wb = '0;

  always #5 saat = ~saat;

  seri_besleyici #(.VERI_GENISLIGI(W), .BOLME(BA)) u_a (
    .saat(saat), .reset(reset), .yukle(ya), .veri(va),
    .cikis_bit(ca), .bit_adim(aa), .mesgul(ma), .bitti(da));

  seri_besleyici #(.VERI_GENISLIGI(W), .BOLME(BB)) u_b (
    .saat(saat), .reset(reset), .yukle(yb), .veri(vb),
    .cikis_bit(cb), .bit_adim(ab), .mesgul(mb), .bitti(db));

  // Expected {cikis_bit, bit_adim, mesgul, bitti} at t cycles after acceptance.
  function automatic logic [3:0] beklenen(int t, logic [W-1:0] w, int bolme, int busy);
    int idx;
    logic c;
    if (t >= 1 && t <= busy) begin
      idx = (t - 1) / bolme;
      c = (idx < W) ? w[W-1-idx] : ^w;
      return {c, ((t - 1) % bolme) == 0, 1'b1, 1'b0};
    end else if (t == busy + 1) begin
      return 4'b1001;
    end
    return 4'b1000;
  endfunction

  function automatic int ilerle(int t, logic y, int busy);
    if ((t == 0 || t > busy) && y) return 1;
    if (t == 0) return 0;
    return (t > busy) ? 0 : t + 1;
  endfunction

  task automatic kontrol(string tag, logic obs, logic exp);
    toplam++;
    assert (obs === exp) else begin
      hata++;
      $error("FAIL %s: observed %b expected %b (t=%0d)", tag, obs, exp, $time);
    end
  endtask

  task automatic hepsini_kontrol();
    logic [3:0] ea, eb;
    ea = beklenen(ta, wa, BA, BUSY_A);
    eb = beklenen(tb, wb, BB, BUSY_B);
    kontrol("a_cikis_bit", ca, ea[3]);
    kontrol("a_bit_adim",  aa, ea[2]);
    kontrol("a_mesgul",    ma, ea[1]);
    kontrol("a_bitti",     da, ea[0]);
    kontrol("b_cikis_bit", cb, eb[3]);
    kontrol("b_bit_adim",  ab, eb[2]);
    kontrol("b_mesgul",    mb, eb[1]);
    kontrol("b_bitti",     db, eb[0]);
  endtask

  // One clock: model samples inputs at the edge, outputs checked 1 ns later.
  task automatic adim();
    logic sya, syb;
    logic [W-1:0] sva, svb;
    sya = ya; syb = yb; sva = va; svb = vb;
    @(posedge saat);
    if ((ta == 0 || ta > BUSY_A) && sya) wa = sva;
    if ((tb == 0 || tb > BUSY_B) && syb) wb = svb;
    ta = ilerle(ta, sya, BUSY_A);
    tb = ilerle(tb, syb, BUSY_B);
    #1;
    hepsini_kontrol();
  endtask

  task automatic adimlar(int n);
    for (int i = 0; i < n; i++) adim();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #3 reset = 1'b1;
    #1;
    ta = 0; tb = 0;
    hepsini_kontrol();
    #2 reset = 1'b0;
  endtask

  initial begin
    // Reset held over a few edges, then released.
    repeat (3) @(posedge saat);
    #1;
    ta = 0; tb = 0;
    hepsini_kontrol();
    reset = 1'b0;
    adimlar(3);
    async_reset();
    adimlar(3);

    // Basic word on A; B runs back-to-back with A5 the whole directed phase.
    yb = 1'b1; vb = 8'hA5;
    ya = 1'b1; va = 8'b1011_0010;
    adim();
    ya = 1'b0; va = '0;
    adimlar(BUSY_A + 4);

    // Odd-parity-weight word (parity bit 1 when enabled).
    ya = 1'b1; va = 8'b1011_0011;
    adim();
    ya = 1'b0;
    adimlar(BUSY_A + 4);

    // Load attempt at cycle 10 of a transfer is ignored.
    ya = 1'b1; va = 8'h6C;
    adim();
    ya = 1'b0;
    adimlar(8);
    ya = 1'b1; va = 8'hFF;
    adim();
    ya = 1'b0; va = '0;
    adimlar(BUSY_A + 6);

    // Reset during cycle 12, then a fresh load restarts from the MSB.
    ya = 1'b1; va = 8'b1101_0110;
    adim();
    ya = 1'b0;
    adimlar(11);
    async_reset();
    adimlar(2);
    ya = 1'b1; va = 8'b0111_1001;
    adim();
    ya = 1'b0;
    adimlar(BUSY_A + 3);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      ya = ($urandom % 6) == 0;
      va = W'($urandom);
      yb = ($urandom % 3) != 0;
      vb = W'($urandom);
      if (($urandom % 97) == 0) async_reset();
      adim();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", toplam, hata);
    $finish;
  end

endmodule
